// File: rtl/fpnew_divsqrt_arbiter_pkg.sv
// fpnew_divsqrt_arbiter_pkg: fpnew type slice plus arbiter state and request types
package fpnew_divsqrt_arbiter_pkg;
  localparam int unsigned FLEN = 64;
  typedef enum logic [3:0] {FMADD, FNMSUB, ADD, MUL, DIV, SQRT} operation_e;
  typedef enum logic [2:0] {RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100, DYN = 3'b111} roundmode_e;
  typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
  typedef enum logic [1:0] {IDLE, OFFER, WAIT} arb_state_e;
  typedef struct packed {
    logic [1:0][FLEN-1:0] operands;
    operation_e           op;
    roundmode_e           rnd_mode;
    fp_format_e           dst_fmt;
  } divsqrt_req_t;
endpackage

// File: rtl/fpnew_divsqrt_arbiter_if.sv
// fpnew_divsqrt_arbiter_if: requester-side and unit-side handshakes of the divsqrt arbiter
interface fpnew_divsqrt_arbiter_if
  import fpnew_divsqrt_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned Width  = 64,
  parameter int unsigned IdxW   = $clog2(NumReq)
) ();
  logic                               flush_i;
  logic [NumReq-1:0]                  req_valid_i;
  logic [NumReq-1:0]                  req_ready_o;
  logic [NumReq-1:0][1:0][Width-1:0]  req_operands_i;
  operation_e [NumReq-1:0]            req_op_i;
  roundmode_e [NumReq-1:0]            req_rnd_mode_i;
  fp_format_e [NumReq-1:0]            req_dst_fmt_i;
  logic [NumReq-1:0]                  rsp_valid_o;
  logic [NumReq-1:0]                  rsp_ready_i;
  logic [Width-1:0]                   rsp_result_o;
  status_t                            rsp_status_o;
  logic                               unit_valid_o;
  logic                               unit_ready_i;
  logic [1:0][Width-1:0]              unit_operands_o;
  operation_e                         unit_op_o;
  roundmode_e                         unit_rnd_mode_o;
  fp_format_e                         unit_dst_fmt_o;
  logic [IdxW-1:0]                    unit_tag_o;
  logic                               unit_out_valid_i;
  logic                               unit_out_ready_o;
  logic [Width-1:0]                   unit_result_i;
  status_t                            unit_status_i;
  logic [IdxW-1:0]                    unit_tag_i;
  logic                               unit_flush_o;
  logic                               busy_o;
  modport slave (
    input  flush_i, req_valid_i, req_operands_i, req_op_i, req_rnd_mode_i, req_dst_fmt_i,
           rsp_ready_i, unit_ready_i, unit_out_valid_i, unit_result_i, unit_status_i, unit_tag_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o, unit_valid_o, unit_operands_o,
           unit_op_o, unit_rnd_mode_o, unit_dst_fmt_o, unit_tag_o, unit_out_ready_o, unit_flush_o, busy_o
  );
  modport master (
    output flush_i, req_valid_i, req_operands_i, req_op_i, req_rnd_mode_i, req_dst_fmt_i,
           rsp_ready_i, unit_ready_i, unit_out_valid_i, unit_result_i, unit_status_i, unit_tag_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o, unit_valid_o, unit_operands_o,
           unit_op_o, unit_rnd_mode_o, unit_dst_fmt_o, unit_tag_o, unit_out_ready_o, unit_flush_o, busy_o
  );
endinterface

// File: rtl/fpnew_rr_pick.sv
// fpnew_rr_pick: combinational round-robin picker, first valid index at or above ptr with wrap
module fpnew_rr_pick #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] idx,
  output logic            any
);
  logic [2*N-1:0] rot;
  logic [IdxW-1:0] off;
  logic [IdxW:0]   sum;
  // rotating the doubled vector puts the pointer's slot at bit 0
  assign rot = {valid, valid} >> ptr;
  assign any = |valid;
  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) off = IdxW'(k);
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = sum >= (IdxW+1)'(N) ? IdxW'(sum - (IdxW+1)'(N)) : sum[IdxW-1:0];
endmodule

// File: rtl/fpnew_divsqrt_arbiter.sv
// fpnew_divsqrt_arbiter: round-robin sharing of one divsqrt unit, result routed back to its owner
module fpnew_divsqrt_arbiter
  import fpnew_divsqrt_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned Width  = 64,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  fpnew_divsqrt_arbiter_if.slave bus
);
  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick, sel;
  logic                  any, issue, accept, rsp_hs;
  logic [1:0][Width-1:0] sel_ops;
  divsqrt_req_t          sel_req;

  fpnew_rr_pick #(.N(NumReq), .IdxW(IdxW)) i_pick (
    .valid (bus.req_valid_i),
    .ptr   (rr_ptr_q),
    .idx   (pick),
    .any   (any)
  );

  // once offered, the grant is locked so the unit sees a stable payload
  assign sel     = state_q == IDLE ? pick : grant_q;
  assign sel_ops = bus.req_operands_i[sel];
  assign sel_req = '{operands: sel_ops, op: bus.req_op_i[sel], rnd_mode: bus.req_rnd_mode_i[sel],
                     dst_fmt: bus.req_dst_fmt_i[sel]};
  assign issue   = (state_q == IDLE && any) || state_q == OFFER;
  assign accept  = issue && bus.unit_ready_i && !bus.flush_i;
  assign rsp_hs  = state_q == WAIT && bus.unit_out_valid_i && bus.rsp_ready_i[grant_q];

  assign bus.unit_valid_o     = issue;
  assign bus.unit_operands_o  = sel_req.operands;
  assign bus.unit_op_o        = sel_req.op;
  assign bus.unit_rnd_mode_o  = sel_req.rnd_mode;
  assign bus.unit_dst_fmt_o   = sel_req.dst_fmt;
  assign bus.unit_tag_o       = sel;
  assign bus.unit_flush_o     = bus.flush_i;
  assign bus.req_ready_o      = accept ? NumReq'(1) << sel : '0;
  assign bus.rsp_valid_o      = state_q == WAIT && bus.unit_out_valid_i && !bus.flush_i ? NumReq'(1) << grant_q : '0;
  // a stray result outside WAIT has no owner and is simply drained
  assign bus.unit_out_ready_o = state_q == WAIT ? bus.rsp_ready_i[grant_q] : bus.unit_out_valid_i;
  assign bus.rsp_result_o     = bus.unit_result_i;
  assign bus.rsp_status_o     = bus.unit_status_i;
  assign bus.busy_o           = state_q != IDLE;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (bus.flush_i) state_d = IDLE;
    else if (state_q == IDLE && any) begin
      grant_d = pick;
      state_d = bus.unit_ready_i ? WAIT : OFFER;
    end
    else if (state_q == OFFER && bus.unit_ready_i) state_d = WAIT;
    else if (rsp_hs) state_d = IDLE;
    if (accept) rr_ptr_d = sel == IdxW'(NumReq - 1) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  tag_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.unit_out_valid_i |-> state_q == WAIT && bus.unit_tag_i == grant_q);
endmodule

// File: tb/tb_fpnew_divsqrt_arbiter.sv
// tb_fpnew_divsqrt_arbiter: directed vectors for the shared divsqrt arbiter
module tb_fpnew_divsqrt_arbiter;
  import fpnew_divsqrt_arbiter_pkg::*;
  localparam logic [63:0] A0 = 64'h4010_0000_0000_0000, B0 = 64'h0;
  localparam logic [63:0] A1 = 64'h4000_0000_0000_0000, B1 = 64'h4000_0000_0000_0000;
  localparam logic [63:0] RES = 64'h3FF0_0000_0000_0000, R2 = 64'h4000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] order = 4'b1010;
  logic [1:0] pend;
  logic [1:0] oh;

  always #5 clk = ~clk;

  fpnew_divsqrt_arbiter_if #(.NumReq(2), .Width(64)) bus ();

  fpnew_divsqrt_arbiter #(.NumReq(2), .Width(64)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // requesters must not withdraw a request before it is accepted
  always @(posedge clk or negedge rst_ni)
    if (!rst_ni) pend <= '0;
    else pend <= bus.req_valid_i & ~bus.req_ready_o;

  always @(negedge clk)
    if (rst_ni) assert ((pend & ~bus.req_valid_i) == 2'b00) else $error("request withdrawn before ready");

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    bus.flush_i = 1'b0;
    bus.req_valid_i = 2'b00;
    bus.req_operands_i[0] = {B0, A0};
    bus.req_operands_i[1] = {B1, A1};
    bus.req_op_i[0] = SQRT;
    bus.req_op_i[1] = DIV;
    bus.req_rnd_mode_i[0] = RNE;
    bus.req_rnd_mode_i[1] = RTZ;
    bus.req_dst_fmt_i[0] = FP64;
    bus.req_dst_fmt_i[1] = FP64;
    bus.rsp_ready_i = 2'b00;
    bus.unit_ready_i = 1'b0;
    bus.unit_out_valid_i = 1'b0;
    bus.unit_result_i = '0;
    bus.unit_status_i = '0;
    bus.unit_tag_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready_o, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid_o, 2'b00);
    chk("rst_unit_valid", bus.unit_valid_o, 0);
    chk("rst_out_ready", bus.unit_out_ready_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    cyc();
    rst_ni = 1'b1;
    // single requester 1, unit ready at once
    bus.req_valid_i = 2'b10;
    bus.unit_ready_i = 1'b1;
    @(negedge clk);
    chk("t1_unit_valid", bus.unit_valid_o, 1);
    chk("t1_tag", bus.unit_tag_o, 1);
    chk("t1_req_ready", bus.req_ready_o, 2'b10);
    chk("t1_op", bus.unit_op_o, DIV);
    chk("t1_rnd", bus.unit_rnd_mode_o, RTZ);
    chk("t1_opa", bus.unit_operands_o[0], A1);
    chk("t1_busy_idle", bus.busy_o, 0);
    cyc();
    bus.req_valid_i = 2'b00;
    bus.unit_ready_i = 1'b0;
    bus.unit_out_valid_i = 1'b1;
    bus.unit_tag_i = 1'b1;
    bus.unit_result_i = RES;
    bus.unit_status_i = 5'b00001;
    bus.rsp_ready_i = 2'b10;
    @(negedge clk);
    chk("t1_rsp_valid", bus.rsp_valid_o, 2'b10);
    chk("t1_rsp_result", bus.rsp_result_o, RES);
    chk("t1_rsp_status", bus.rsp_status_o, 5'b00001);
    chk("t1_out_ready", bus.unit_out_ready_o, 1);
    chk("t1_busy_wait", bus.busy_o, 1);
    chk("t1_no_issue_wait", bus.unit_valid_o, 0);
    cyc();
    bus.unit_out_valid_i = 1'b0;
    @(negedge clk);
    chk("t1_back_idle", bus.busy_o, 0);
    chk("t1_rsp_clear", bus.rsp_valid_o, 2'b00);
    // both continuously valid: grants alternate 0,1,0,1
    cyc();
    bus.req_valid_i = 2'b11;
    bus.unit_ready_i = 1'b1;
    bus.rsp_ready_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      oh = order[k] ? 2'b10 : 2'b01;
      @(negedge clk);
      chk("rr_tag", bus.unit_tag_o, order[k]);
      chk("rr_req_ready", bus.req_ready_o, oh);
      chk("rr_issue_in_idle", bus.busy_o, 0);
      cyc();
      if (k == 3) begin
        bus.req_valid_i = 2'b01;
        bus.unit_ready_i = 1'b0;
      end
      bus.unit_out_valid_i = 1'b1;
      bus.unit_tag_i = order[k];
      bus.unit_result_i = 64'h100 + 64'(k);
      @(negedge clk);
      chk("rr_rsp_valid", bus.rsp_valid_o, oh);
      chk("rr_bubble", bus.unit_valid_o, 0);
      chk("rr_stall", bus.req_ready_o, 2'b00);
      chk("rr_result", bus.rsp_result_o, 64'h100 + 64'(k));
      cyc();
      bus.unit_out_valid_i = 1'b0;
    end
    // unit not ready: grant locked to 0 in OFFER while requester 1 waits
    @(negedge clk);
    chk("offer_valid", bus.unit_valid_o, 1);
    chk("offer_tag0", bus.unit_tag_o, 0);
    chk("offer_no_ready", bus.req_ready_o, 2'b00);
    cyc();
    bus.req_valid_i = 2'b11;
    repeat (2) begin
      @(negedge clk);
      chk("offer_tag", bus.unit_tag_o, 0);
      chk("offer_opa", bus.unit_operands_o[0], A0);
      chk("offer_op", bus.unit_op_o, SQRT);
      chk("offer_req_ready", bus.req_ready_o, 2'b00);
      chk("offer_busy", bus.busy_o, 1);
      cyc();
    end
    bus.unit_ready_i = 1'b1;
    @(negedge clk);
    chk("offer_accept", bus.req_ready_o, 2'b01);
    chk("offer_accept_tag", bus.unit_tag_o, 0);
    cyc();
    bus.req_valid_i = 2'b10;
    // response backpressure from requester 0
    bus.unit_out_valid_i = 1'b1;
    bus.unit_tag_i = 1'b0;
    bus.unit_result_i = R2;
    bus.rsp_ready_i = 2'b00;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_ready", bus.unit_out_ready_o, 0);
      chk("bp_rsp_valid", bus.rsp_valid_o, 2'b01);
      chk("bp_stall", bus.req_ready_o, 2'b00);
      cyc();
    end
    bus.rsp_ready_i = 2'b01;
    @(negedge clk);
    chk("bp_release", bus.unit_out_ready_o, 1);
    chk("bp_result", bus.rsp_result_o, R2);
    cyc();
    bus.unit_out_valid_i = 1'b0;
    @(negedge clk);
    chk("bp_idle", bus.busy_o, 0);
    chk("fair_tag1", bus.unit_tag_o, 1);
    chk("fair_ready1", bus.req_ready_o, 2'b10);
    cyc();
    bus.req_valid_i = 2'b00;
    // flush while waiting on requester 1
    bus.flush_i = 1'b1;
    bus.unit_out_valid_i = 1'b1;
    bus.unit_tag_i = 1'b1;
    bus.rsp_ready_i = 2'b10;
    @(negedge clk);
    chk("fl_unit_flush", bus.unit_flush_o, 1);
    chk("fl_rsp_valid", bus.rsp_valid_o, 2'b00);
    cyc();
    bus.unit_out_valid_i = 1'b0;
    bus.req_valid_i = 2'b11;
    @(negedge clk);
    chk("fl_idle", bus.busy_o, 0);
    chk("fl_accept_blocked", bus.req_ready_o, 2'b00);
    cyc();
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("fl_still_idle", bus.busy_o, 0);
    chk("fl_next_tag", bus.unit_tag_o, 0);
    chk("fl_next_ready", bus.req_ready_o, 2'b01);
    cyc();
    bus.req_valid_i = 2'b10;
    // asynchronous reset in WAIT
    @(negedge clk);
    chk("rw_busy", bus.busy_o, 1);
    #1;
    rst_ni = 1'b0;
    bus.req_valid_i = 2'b00;
    #1;
    chk("rw_busy_clr", bus.busy_o, 0);
    chk("rw_unit_valid", bus.unit_valid_o, 0);
    chk("rw_req_ready", bus.req_ready_o, 2'b00);
    chk("rw_rsp_valid", bus.rsp_valid_o, 2'b00);
    chk("rw_out_ready", bus.unit_out_ready_o, 0);
    cyc();
    rst_ni = 1'b1;
    bus.req_valid_i = 2'b11;
    @(negedge clk);
    chk("rw_ptr_tag", bus.unit_tag_o, 0);
    chk("rw_ptr_ready", bus.req_ready_o, 2'b01);
    chk("rw_idle", bus.busy_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
